// File: rtl/vmem_seq_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vmem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } vseq_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int LANE_BYTES = DEF_DATA_W / 8;

    // Unit stride in bytes for a given lane width.
    function automatic int lane_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/vmem_lane_buf.sv
// LANES x DATA_W load-assembly buffer with a single lane write port.
module vmem_lane_buf
    import vmem_seq_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_W-1:0]       wdata,
    output logic [LANES*DATA_W-1:0] ld_vec
);

    logic [DATA_W-1:0] lanes [LANES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) lanes[i] <= '0;
        end else if (we) begin
            lanes[widx] <= wdata;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_flat
        assign ld_vec[g*DATA_W +: DATA_W] = lanes[g];
    end

endmodule

// File: rtl/vmem_sequencer.sv
// Serialises vld/vst into LANES single-word memory beats and stalls upstream meanwhile.
// Optional per-op byte stride port enabled by defining VMEM_SEQ_STRIDE_EN.
module vmem_sequencer
    import vmem_seq_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*DATA_W-1:0] st_vec,
`ifdef VMEM_SEQ_STRIDE_EN
    input  logic [15:0]             stride,
`endif
    output logic                    stall,
    output logic                    done,
    output logic                    ld_valid,
    output logic [LANES*DATA_W-1:0] ld_vec,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ready
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    vseq_state_t             state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    op_store;
    logic [ADDR_W-1:0]       stride_in;
    logic [ADDR_W-1:0]       stride_q;
    logic [LANES*DATA_W-1:0] st_q;
    logic                    beat_last;
    logic                    lane_we;

`ifdef VMEM_SEQ_STRIDE_EN
    assign stride_in = ADDR_W'(stride);
`else
    assign stride_in = ADDR_W'(lane_bytes(DATA_W));
`endif

    assign idx_nxt   = IDX_W'(idx + 1'b1);
    assign beat_last = (idx == IDX_W'(LANES - 1));
    assign lane_we   = (state == XFER) && mem_ready && !op_store;
    assign stall     = ((state == IDLE) && start) || (state == XFER);

    // Address advances by accumulation, so base + idx*stride wraps modulo 2^ADDR_W for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            op_store  <= 1'b0;
            stride_q  <= '0;
            st_q      <= '0;
            done      <= 1'b0;
            ld_valid  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    ld_valid <= 1'b0;
                    if (start) begin
                        state     <= XFER;
                        idx       <= '0;
                        op_store  <= is_store;
                        stride_q  <= stride_in;
                        st_q      <= st_vec;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= base_addr;
                        mem_wdata <= st_vec[DATA_W-1:0];
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        idx <= idx_nxt;
                        if (beat_last) begin
                            state    <= DONE;
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            done     <= 1'b1;
                            ld_valid <= !op_store;
                        end else begin
                            mem_addr  <= mem_addr + stride_q;
                            mem_wdata <= st_q[idx_nxt*DATA_W +: DATA_W];
                        end
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    ld_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    vmem_lane_buf #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_lane_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (lane_we),
        .widx   (idx),
        .wdata  (mem_rdata),
        .ld_vec (ld_vec)
    );

endmodule

// File: tb/tb_vmem_sequencer.sv
// Directed bench for vmem_sequencer with a per-cycle transaction model and literal pins.
module tb_vmem_sequencer;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [31:0]  base_addr;
    logic [127:0] st_vec;
    logic [15:0]  stride;
    logic         stall;
    logic         done;
    logic         ld_valid;
    logic [127:0] ld_vec;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ready;

    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic [127:0] model_vec;
    logic [31:0]  seen_addr[$];
    int           done_cyc;
    int           w0[4] = '{0, 0, 0, 0};
    int           w2[4] = '{0, 0, 2, 0};

    always #5 clk = ~clk;

    vmem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .st_vec    (st_vec),
`ifdef VMEM_SEQ_STRIDE_EN
        .stride    (stride),
`endif
        .stall     (stall),
        .done      (done),
        .ld_valid  (ld_valid),
        .ld_vec    (ld_vec),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},    stall,     0);
        chk({tag, "_done"},     done,      0);
        chk({tag, "_ldvalid"},  ld_valid,  0);
        chk({tag, "_ldvec"},    ld_vec,    0);
        chk({tag, "_req"},      mem_req,   0);
        chk({tag, "_we"},       mem_we,    0);
        chk({tag, "_addr"},     mem_addr,  0);
        chk({tag, "_wdata"},    mem_wdata, 0);
    endtask

    // Model: cycle 0 request, then one beat per lane stretched by its wait count, then a done cycle.
    task automatic run_op(input bit st, input logic [31:0] base, input logic [15:0] strd,
                          input logic [127:0] svec, input logic [127:0] words,
                          input int waits[4], output int dcyc);
        int cyc;
        logic [31:0] ea;
        seen_addr.delete();
        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = base; st_vec = svec; stride = strd;
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        cyc = 0;
        chk("c0_stall", stall, 1);
        chk("c0_req", mem_req, 0);
        chk("c0_done", done, 0);
        for (int k = 0; k < LANES; k++) begin
            ea = base + 32'(k) * 32'(strd);
            for (int w = 0; w <= waits[k]; w++) begin
                @(negedge clk);
                mem_ready = (w == waits[k]);
                mem_rdata = mem_ready ? words[k*32 +: 32] : $urandom;
                #1;
                cyc++;
                seen_addr.push_back(mem_addr);
                chk("beat_stall", stall, 1);
                chk("beat_req", mem_req, 1);
                chk("beat_we", mem_we, st);
                chk("beat_addr", mem_addr, ea);
                chk("beat_done", done, 0);
                if (st) chk("beat_wdata", mem_wdata, svec[k*32 +: 32]);
            end
            if (!st) model_vec[k*32 +: 32] = words[k*32 +: 32];
        end
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        cyc++;
        dcyc = cyc;
        chk("dn_done", done, 1);
        chk("dn_ldvalid", ld_valid, !st);
        chk("dn_stall", stall, 0);
        chk("dn_req", mem_req, 0);
        chk("dn_ldvec", ld_vec, model_vec);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("idle_done", done, 0);
        chk("idle_ldvalid", ld_valid, 0);
        chk("idle_stall", stall, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_ldvec", ld_vec, model_vec);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; st_vec = '0;
        stride = 16'd4; mem_rdata = '0; mem_ready = 1'b0;
        model_vec = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;

        // Unit-stride load
        run_op(0, 32'h100, 16'd4, '0,
               {32'h44, 32'h33, 32'h22, 32'h11}, w0, done_cyc);
        chk("lit_ld_donecyc", done_cyc, 5);
        chk("lit_ld_a0", seen_addr[0], 32'h100);
        chk("lit_ld_a1", seen_addr[1], 32'h104);
        chk("lit_ld_a2", seen_addr[2], 32'h108);
        chk("lit_ld_a3", seen_addr[3], 32'h10C);
        chk("lit_ld_vec", ld_vec, {32'h44, 32'h33, 32'h22, 32'h11});

        // Store; load vector must be retained
        run_op(1, 32'h200, 16'd4, {32'hD, 32'hC, 32'hB, 32'hA},
               '0, w0, done_cyc);
        chk("lit_st_donecyc", done_cyc, 5);
        chk("lit_st_a3", seen_addr[3], 32'h20C);

        // Load with two not-ready cycles on lane 2
        run_op(0, 32'h400, 16'd4, '0,
               {32'hDD, 32'hCC, 32'hBB, 32'hAA}, w2, done_cyc);
        chk("lit_wt_donecyc", done_cyc, 7);
        chk("lit_wt_hold0", seen_addr[2], 32'h408);
        chk("lit_wt_hold1", seen_addr[3], 32'h408);
        chk("lit_wt_hold2", seen_addr[4], 32'h408);
        chk("lit_wt_vec", ld_vec, {32'hDD, 32'hCC, 32'hBB, 32'hAA});

        // Address wrap-around
        run_op(0, 32'hFFFF_FFF8, 16'd4, '0,
               {32'h4, 32'h3, 32'h2, 32'h1}, w0, done_cyc);
        chk("lit_wr_a0", seen_addr[0], 32'hFFFF_FFF8);
        chk("lit_wr_a1", seen_addr[1], 32'hFFFF_FFFC);
        chk("lit_wr_a2", seen_addr[2], 32'h0);
        chk("lit_wr_a3", seen_addr[3], 32'h4);

        // Reset in the middle of a load
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; base_addr = 32'h300; mem_ready = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        #1;
        chk("mr_req", mem_req, 1);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        chk_all_zero("mr");
        model_vec = '0;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("mr_nodone", done, 0);
            chk("mr_noreq", mem_req, 0);
        end
        run_op(0, 32'h500, 16'd4, '0,
               {32'h9, 32'h8, 32'h7, 32'h6}, w0, done_cyc);
        chk("lit_mr_donecyc", done_cyc, 5);

`ifdef VMEM_SEQ_STRIDE_EN
        run_op(0, 32'h0, 16'd16, '0,
               {32'hF4, 32'hF3, 32'hF2, 32'hF1}, w0, done_cyc);
        chk("lit_sd_a0", seen_addr[0], 32'd0);
        chk("lit_sd_a1", seen_addr[1], 32'd16);
        chk("lit_sd_a2", seen_addr[2], 32'd32);
        chk("lit_sd_a3", seen_addr[3], 32'd48);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
